data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares the single-port data memory between the MEM pipeline stage and the debug unit.
- Pass-through for MEM-stage loads/stores while idle.
- On debug request, runs a dump sequencer that reads DUMP_WORDS words from word 0 and streams them out over a valid/ready handshake.
- The pipeline is stalled while a dump owns the memory. Sits between the MEM stage and data_memory.

Parameters:
NUM_BYTES, 4, byte lanes per word (width of byte enables)
TAM_DATA, 32, data and byte-address width
NUM_DIREC, 7, word-index width of the debug pointer
DUMP_WORDS, 128, words per dump; legal range 1 .. 2**NUM_DIREC

Ports:
i_clock  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-high reset
i_pipe_rd_mem  in  1  MEM-stage load request
i_pipe_wr_mem  in  1  MEM-stage store request
i_pipe_byte_enb  in  NUM_BYTES  store byte enables
i_pipe_addr  in  TAM_DATA  MEM-stage byte address
i_pipe_data  in  TAM_DATA  store data
o_pipe_stall  out  1  MEM-stage access not serviced this cycle
i_dbg_dump_start  in  1  request full memory dump (1-cycle pulse or level)
o_dbg_busy  out  1  dump pending or in progress
o_dbg_valid  out  1  o_dbg_data/o_dbg_addr hold a dumped word
i_dbg_ready  in  1  debug unit accepts current word
o_dbg_data  out  TAM_DATA  dumped word
o_dbg_addr  out  NUM_DIREC  word index of o_dbg_data
o_dbg_done  out  1  one-cycle pulse after the last word is accepted
o_mem_wr_en  out  1  memory write enable
o_mem_byte_enb  out  NUM_BYTES  memory byte enables
o_mem_addr  out  TAM_DATA  memory byte address
o_mem_data  out  TAM_DATA  memory write data
i_mem_rdata  in  TAM_DATA  memory read data, valid one cycle after address

Behaviour:
- FSM states: IDLE, RD, WAIT, OUT, DONE. Register idx [NUM_DIREC], flag pend.
- Reset (async, any state, including mid-dump):
  - state=IDLE, idx=0, pend=0.
  - o_dbg_valid=0, o_dbg_data=0, o_dbg_addr=0, o_dbg_done=0, o_dbg_busy=0.
  - Memory outputs reflect the pipeline pass-through, with o_mem_wr_en gated by i_pipe_wr_mem. The dump restarts only on a new start request.
- IDLE, memory path:
  - Memory outputs are a combinational pass-through of the pipe inputs.
  - o_mem_wr_en = i_pipe_wr_mem; o_pipe_stall=0.
- IDLE, start handling:
  - Start with no pipe request -> RD.
  - Start during a pipe request: the pipe access is serviced that cycle and pend is set. Next cycle with no pipe request -> RD.
  - While pend=1, new pipe requests are stalled so the dump cannot starve.
- RD:
  - o_mem_addr = idx<<2 (zero-extended), o_mem_wr_en=0, o_mem_byte_enb all ones. -> WAIT.
- WAIT: address held; at the edge o_dbg_data<=i_mem_rdata, o_dbg_addr<=idx, o_dbg_valid<=1. -> OUT.
- OUT:
  - Outputs held stable until i_dbg_ready.
  - On valid&&ready, o_dbg_valid<=0.
  - If idx==DUMP_WORDS-1 -> DONE; else idx<=idx+1 -> RD.
- DONE: o_dbg_done=1 for exactly one cycle, idx<=0, pend<=0. -> IDLE.
- Latency and throughput:
  - Start accepted at edge k -> o_dbg_valid high after edge k+2.
  - With ready tied high, one word per 3 cycles.
- o_dbg_busy = pend || state!=IDLE.
- In all non-IDLE states:
  - o_pipe_stall = i_pipe_rd_mem || i_pipe_wr_mem.
  - Pipe writes are never forwarded (o_mem_wr_en=0).
- Start asserted while busy: ignored; no restart, no queuing.
- idx never exceeds DUMP_WORDS-1. With DUMP_WORDS=2**NUM_DIREC, the last index is all ones and no wrap is observable.

Optional Feature:
DUMP_SKIP_ZERO_EN
- Defined: in WAIT, if i_mem_rdata==0, the word is not presented (o_dbg_valid stays 0).
  - If idx==DUMP_WORDS-1 -> DONE; else idx+1 -> RD.
  - o_dbg_done still pulses even if every word was zero.
- Undefined: every word is presented, as above.

Decomposition:
- Shared package (mips_pkg): FSM state enum (IDLE/RD/WAIT/OUT/DONE), NUM_BYTES/TAM_DATA/NUM_DIREC defaults, byte-to-word shift constant (2).
- One natural sub-module: dump_sequencer (FSM, idx, output register, handshake). The top holds the pass-through/stall mux.

Test Plan:
- Idle pass-through: i_pipe_wr_mem=1, addr=0x10, data=0xDEADBEEF, byte_enb=4'b0011 -> same on memory port same cycle, o_pipe_stall=0.
- Full dump (DUMP_WORDS=4, memory word i = 0x100+i, ready=1):
  - Start at edge k -> valid at k+2.
  - Words 0x100..0x103 with o_dbg_addr 0..3, one per 3 cycles.
  - o_dbg_done pulses once; busy drops the next cycle.
- Backpressure: hold ready=0 for 5 cycles on word 1 -> data/addr stable, valid held, idx not advanced, no extra memory reads.
- Collision: start and i_pipe_rd_mem same cycle -> pipe serviced (stall=0), busy=1. Pipe request next cycle -> stall=1. Dump begins once the pipe is idle.
- Mid-dump reset: assert i_reset in OUT on word 2 -> valid=0, busy=0 immediately. A fresh start dumps from word 0.
- DUMP_SKIP_ZERO_EN: memory {0,5,0,7} -> only addr1=5 and addr3=7 emitted, then one o_dbg_done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the data-memory arbiter and its dump sequencer.
//   - Default widths: NUM_BYTES_DEF, TAM_DATA_DEF, NUM_DIREC_DEF, DUMP_WORDS_DEF
//   - BYTE_SHIFT: word index -> byte address shift (4-byte words)
//   - dump_state_e: dump sequencer FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int NUM_BYTES_DEF  = 4;
  localparam int TAM_DATA_DEF   = 32;
  localparam int NUM_DIREC_DEF  = 7;
  localparam int DUMP_WORDS_DEF = 128;

  // Word index to byte address: idx << 2.
  localparam int BYTE_SHIFT = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

endpackage

// File: rtl/data_memory_arbiter_dump_sequencer.sv
// -----------------------------------------------------------------------------
// dump_sequencer
// Walks the data memory from word 0 to DUMP_WORDS-1 and streams each word to
// the debug unit. Owns the FSM, the word index, the pending-start flag and the
// registered debug output word.
//
// Optional feature (compile macro DUMP_SKIP_ZERO_EN): when defined, words that
// read back as zero are not presented; the index still advances and the done
// pulse still fires after the last word.
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   dump_start     : dump request (pulse or level); ignored while busy
//   pipe_req       : MEM stage is requesting the memory this cycle
//   mem_rdata      : memory read data, valid one cycle after the address
//   dbg_ready      : debug unit accepts the presented word
//   dbg_valid      : dbg_data/dbg_addr hold a dumped word
//   dbg_data       : dumped word
//   dbg_addr       : word index of dbg_data
//   dbg_done       : one-cycle pulse after the last word
//   busy           : dump pending or in progress
//   pend           : start seen while the pipe held the memory
//   word_idx       : word index currently addressed by the dump
//   state          : current FSM state (debug visibility, drives the top mux)
//
// Handshake: a word transfers on a rising edge where dbg_valid && dbg_ready.
// While dbg_valid is high and dbg_ready low, dbg_data/dbg_addr/dbg_valid are
// held unchanged. dbg_valid never depends combinationally on dbg_ready.
// -----------------------------------------------------------------------------
module dump_sequencer
  import mips_pkg::*;
#(
  parameter int TAM_DATA   = TAM_DATA_DEF,
  parameter int NUM_DIREC  = NUM_DIREC_DEF,
  parameter int DUMP_WORDS = DUMP_WORDS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dump_start,
  input  logic                 pipe_req,
  input  logic [TAM_DATA-1:0]  mem_rdata,
  input  logic                 dbg_ready,
  output logic                 dbg_valid,
  output logic [TAM_DATA-1:0]  dbg_data,
  output logic [NUM_DIREC-1:0] dbg_addr,
  output logic                 dbg_done,
  output logic                 busy,
  output logic                 pend,
  output logic [NUM_DIREC-1:0] word_idx,
  output dump_state_e          state
);

  localparam logic [NUM_DIREC-1:0] LAST_IDX = NUM_DIREC'(DUMP_WORDS - 1);

`ifdef DUMP_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  dump_state_e          state_q;
  dump_state_e          state_d;
  logic [NUM_DIREC-1:0] idx_q;
  logic                 pend_q;
  logic                 valid_q;
  logic [TAM_DATA-1:0]  data_q;
  logic [NUM_DIREC-1:0] addr_q;

  logic last_word;
  logic skip_word;
  logic accept;

  assign last_word = (idx_q == LAST_IDX);
  assign skip_word = SKIP_ZERO && (mem_rdata == '0);
  assign accept    = valid_q && dbg_ready;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. From IDLE the dump only begins on a cycle with no pipe
  // request; a start that collides with a pipe access is remembered in pend.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if ((dump_start || pend_q) && !pipe_req) state_d = ST_RD;
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (skip_word) state_d = last_word ? ST_DONE : ST_RD;
        else           state_d = ST_OUT;
      end
      ST_OUT:  if (accept) state_d = last_word ? ST_DONE : ST_RD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    dbg_valid = valid_q;
    dbg_data  = data_q;
    dbg_addr  = addr_q;
    dbg_done  = (state_q == ST_DONE);
    busy      = pend_q || (state_q != ST_IDLE);
    pend      = pend_q;
    word_idx  = idx_q;
    state     = state_q;
  end

  // Index, pending flag and the registered output word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dump_start && !pend_q && pipe_req) pend_q <= 1'b1;
        end
        ST_WAIT: begin
          if (skip_word) begin
            if (!last_word) idx_q <= idx_q + NUM_DIREC'(1);
          end else begin
            data_q  <= mem_rdata;
            addr_q  <= idx_q;
            valid_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (!last_word) idx_q <= idx_q + NUM_DIREC'(1);
          end
        end
        ST_DONE: begin
          idx_q  <= '0;
          pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Shares the single-port data memory between the MEM pipeline stage and the
// debug dump sequencer. While the sequencer is idle the memory port is a
// combinational pass-through of the pipe request; while a dump owns the
// memory, the pipe is stalled and the sequencer drives read addresses.
//
// Optional feature (compile macro DUMP_SKIP_ZERO_EN): zero words are skipped
// by the dump sequencer instead of being presented.
//
// Ports:
//   i_clock, i_reset      : rising-edge clock, asynchronous active-high reset
//   i_pipe_rd_mem/wr_mem  : MEM-stage load / store request
//   i_pipe_byte_enb       : store byte enables
//   i_pipe_addr           : MEM-stage byte address
//   i_pipe_data           : store data
//   o_pipe_stall          : MEM-stage access not serviced this cycle
//   i_dbg_dump_start      : request a full memory dump
//   o_dbg_busy            : dump pending or in progress
//   o_dbg_valid/i_dbg_ready : dump word handshake
//   o_dbg_data/o_dbg_addr : dumped word and its word index
//   o_dbg_done            : one-cycle pulse after the last word
//   o_mem_*               : memory write enable, byte enables, address, data
//   i_mem_rdata           : memory read data (one cycle after address)
// -----------------------------------------------------------------------------
module data_memory_arbiter
  import mips_pkg::*;
#(
  parameter int NUM_BYTES  = NUM_BYTES_DEF,
  parameter int TAM_DATA   = TAM_DATA_DEF,
  parameter int NUM_DIREC  = NUM_DIREC_DEF,
  parameter int DUMP_WORDS = DUMP_WORDS_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_pipe_rd_mem,
  input  logic                 i_pipe_wr_mem,
  input  logic [NUM_BYTES-1:0] i_pipe_byte_enb,
  input  logic [TAM_DATA-1:0]  i_pipe_addr,
  input  logic [TAM_DATA-1:0]  i_pipe_data,
  output logic                 o_pipe_stall,
  input  logic                 i_dbg_dump_start,
  output logic                 o_dbg_busy,
  output logic                 o_dbg_valid,
  input  logic                 i_dbg_ready,
  output logic [TAM_DATA-1:0]  o_dbg_data,
  output logic [NUM_DIREC-1:0] o_dbg_addr,
  output logic                 o_dbg_done,
  output logic                 o_mem_wr_en,
  output logic [NUM_BYTES-1:0] o_mem_byte_enb,
  output logic [TAM_DATA-1:0]  o_mem_addr,
  output logic [TAM_DATA-1:0]  o_mem_data,
  input  logic [TAM_DATA-1:0]  i_mem_rdata
);

  logic                 pipe_req;
  logic                 seq_pend;
  logic [NUM_DIREC-1:0] word_idx;
  dump_state_e          seq_state;
  logic                 mem_owned;

  assign pipe_req  = i_pipe_rd_mem || i_pipe_wr_mem;
  assign mem_owned = (seq_state != ST_IDLE);

  dump_sequencer #(
    .TAM_DATA   (TAM_DATA),
    .NUM_DIREC  (NUM_DIREC),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump_sequencer (
    .clock      (i_clock),
    .reset      (i_reset),
    .dump_start (i_dbg_dump_start),
    .pipe_req   (pipe_req),
    .mem_rdata  (i_mem_rdata),
    .dbg_ready  (i_dbg_ready),
    .dbg_valid  (o_dbg_valid),
    .dbg_data   (o_dbg_data),
    .dbg_addr   (o_dbg_addr),
    .dbg_done   (o_dbg_done),
    .busy       (o_dbg_busy),
    .pend       (seq_pend),
    .word_idx   (word_idx),
    .state      (seq_state)
  );

  // Memory port mux and pipe stall.
  always_comb begin
    o_mem_addr     = i_pipe_addr;
    o_mem_data     = i_pipe_data;
    o_mem_byte_enb = i_pipe_byte_enb;
    o_mem_wr_en    = i_pipe_wr_mem;
    o_pipe_stall   = 1'b0;
    if (mem_owned) begin
      o_mem_addr     = TAM_DATA'(word_idx) << BYTE_SHIFT;
      o_mem_data     = '0;
      o_mem_byte_enb = '1;
      o_mem_wr_en    = 1'b0;
      o_pipe_stall   = pipe_req;
    end else if (seq_pend) begin
      // A dump is waiting for the pipe to go quiet: hold off new pipe accesses
      // so the dump cannot starve, and never let a stalled store reach memory.
      o_pipe_stall = pipe_req;
      o_mem_wr_en  = i_pipe_wr_mem && !pipe_req;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
// Directed bench for data_memory_arbiter with DUMP_WORDS=4 and a small
// synchronous-read memory model. Dumped words are checked against an expected
// queue filled when each dump is started.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  localparam int NB = 4;
  localparam int TD = 32;
  localparam int ND = 7;
  localparam int DW = 4;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_pipe_rd_mem = 1'b0;
  logic          i_pipe_wr_mem = 1'b0;
  logic [NB-1:0] i_pipe_byte_enb = '0;
  logic [TD-1:0] i_pipe_addr = '0;
  logic [TD-1:0] i_pipe_data = '0;
  logic          o_pipe_stall;
  logic          i_dbg_dump_start = 1'b0;
  logic          o_dbg_busy;
  logic          o_dbg_valid;
  logic          i_dbg_ready = 1'b0;
  logic [TD-1:0] o_dbg_data;
  logic [ND-1:0] o_dbg_addr;
  logic          o_dbg_done;
  logic          o_mem_wr_en;
  logic [NB-1:0] o_mem_byte_enb;
  logic [TD-1:0] o_mem_addr;
  logic [TD-1:0] o_mem_data;
  logic [TD-1:0] i_mem_rdata = '0;

  data_memory_arbiter #(
    .NUM_BYTES(NB), .TAM_DATA(TD), .NUM_DIREC(ND), .DUMP_WORDS(DW)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_pipe_rd_mem    (i_pipe_rd_mem),
    .i_pipe_wr_mem    (i_pipe_wr_mem),
    .i_pipe_byte_enb  (i_pipe_byte_enb),
    .i_pipe_addr      (i_pipe_addr),
    .i_pipe_data      (i_pipe_data),
    .o_pipe_stall     (o_pipe_stall),
    .i_dbg_dump_start (i_dbg_dump_start),
    .o_dbg_busy       (o_dbg_busy),
    .o_dbg_valid      (o_dbg_valid),
    .i_dbg_ready      (i_dbg_ready),
    .o_dbg_data       (o_dbg_data),
    .o_dbg_addr       (o_dbg_addr),
    .o_dbg_done       (o_dbg_done),
    .o_mem_wr_en      (o_mem_wr_en),
    .o_mem_byte_enb   (o_mem_byte_enb),
    .o_mem_addr       (o_mem_addr),
    .o_mem_data       (o_mem_data),
    .i_mem_rdata      (i_mem_rdata)
  );

  // Clock / reset
  always #5 i_clock = ~i_clock;

  // Memory model: 16 words, byte-enabled writes, read data one cycle later.
  logic [TD-1:0] mem [16];
  always @(posedge i_clock) begin
    if (o_mem_wr_en) begin
      for (int b = 0; b < NB; b++)
        if (o_mem_byte_enb[b]) mem[o_mem_addr[5:2]][8*b +: 8] <= o_mem_data[8*b +: 8];
    end
    i_mem_rdata <= mem[o_mem_addr[5:2]];
  end

  // Scoreboard state
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int prev_xfer = 0;
  bit gap_chk = 1'b0;
  bit have_prev = 1'b0;
  logic [ND+TD-1:0] exp_q[$];

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Output monitor: pops one expected word per valid&&ready transfer.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_dbg_done) done_cnt++;
      if (o_dbg_valid && i_dbg_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_queue_depth", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [ND+TD-1:0] e;
          e = exp_q.pop_front();
          check("sb_word", 64'({o_dbg_addr, o_dbg_data}), 64'(e));
        end
        if (gap_chk) begin
          if (have_prev) check("xfer_gap", 64'(cyc - prev_xfer), 64'd3);
          have_prev = 1'b1;
          prev_xfer = cyc;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic pulse_start();
    i_dbg_dump_start = 1'b1;
    tick();
    i_dbg_dump_start = 1'b0;
  endtask

  task automatic pipe_write(input logic [TD-1:0] addr, input logic [TD-1:0] data);
    i_pipe_wr_mem   = 1'b1;
    i_pipe_addr     = addr;
    i_pipe_data     = data;
    i_pipe_byte_enb = '1;
    tick();
    i_pipe_wr_mem   = 1'b0;
  endtask

  task automatic push_word(input int idx, input logic [TD-1:0] data);
    exp_q.push_back({ND'(idx), data});
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!o_dbg_valid && n < budget);
    check("wait_valid", 64'(o_dbg_valid), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!o_dbg_done && n < budget);
    check("wait_done", 64'(o_dbg_done), 64'd1);
  endtask

  task automatic accept_one();
    @(posedge i_clock);
    #1 i_dbg_ready = 1'b1;
    @(posedge i_clock);
    #1 i_dbg_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge i_clock);
    check("rst_valid", 64'(o_dbg_valid), 64'd0);
    check("rst_busy",  64'(o_dbg_busy),  64'd0);
    check("rst_done",  64'(o_dbg_done),  64'd0);
    check("rst_data",  64'(o_dbg_data),  64'd0);
    check("rst_addr",  64'(o_dbg_addr),  64'd0);
    check("rst_stall", 64'(o_pipe_stall), 64'd0);
    i_pipe_wr_mem = 1'b1;
    i_pipe_addr   = 32'h3C;
    #1;
    check("rst_pass_wr",   64'(o_mem_wr_en), 64'd1);
    check("rst_pass_addr", 64'(o_mem_addr),  64'h3C);
    i_pipe_wr_mem = 1'b0;
    tick();
    i_reset = 1'b0;

    // Idle pass-through: store
    i_pipe_wr_mem   = 1'b1;
    i_pipe_addr     = 32'h10;
    i_pipe_data     = 32'hDEADBEEF;
    i_pipe_byte_enb = 4'b0011;
    @(negedge i_clock);
    check("pt_wr_en", 64'(o_mem_wr_en),    64'd1);
    check("pt_addr",  64'(o_mem_addr),     64'h10);
    check("pt_data",  64'(o_mem_data),     64'hDEADBEEF);
    check("pt_be",    64'(o_mem_byte_enb), 64'h3);
    check("pt_stall", 64'(o_pipe_stall),   64'd0);
    tick();
    i_pipe_wr_mem = 1'b0;

    // Idle pass-through: load
    i_pipe_rd_mem = 1'b1;
    i_pipe_addr   = 32'h8;
    @(negedge i_clock);
    check("pt_rd_addr",  64'(o_mem_addr),   64'h8);
    check("pt_rd_wr_en", 64'(o_mem_wr_en),  64'd0);
    check("pt_rd_stall", 64'(o_pipe_stall), 64'd0);
    tick();
    i_pipe_rd_mem = 1'b0;

    // Preload words 0..3
    for (int i = 0; i < DW; i++) pipe_write(TD'(4 * i), TD'(32'h100 + i));

    // Full dump with ready tied high
    i_dbg_ready = 1'b1;
    for (int i = 0; i < DW; i++) push_word(i, TD'(32'h100 + i));
    gap_chk   = 1'b1;
    have_prev = 1'b0;
    pulse_start();
    @(negedge i_clock);
    check("fd_busy_k",   64'(o_dbg_busy),  64'd1);
    check("fd_valid_k",  64'(o_dbg_valid), 64'd0);
    check("fd_rd_addr",  64'(o_mem_addr),  64'd0);
    check("fd_rd_wr_en", 64'(o_mem_wr_en), 64'd0);
    check("fd_rd_be",    64'(o_mem_byte_enb), 64'hF);
    @(negedge i_clock);
    check("fd_valid_k1", 64'(o_dbg_valid), 64'd0);
    @(negedge i_clock);
    check("fd_valid_k2", 64'(o_dbg_valid), 64'd1);
    check("fd_data_k2",  64'(o_dbg_data),  64'h100);
    check("fd_addr_k2",  64'(o_dbg_addr),  64'd0);
    wait_done(20);
    check("fd_busy_done", 64'(o_dbg_busy), 64'd1);
    @(negedge i_clock);
    check("fd_done_once", 64'(o_dbg_done), 64'd0);
    check("fd_busy_drop", 64'(o_dbg_busy), 64'd0);
    check("fd_q_empty",   64'(exp_q.size()), 64'd0);
    gap_chk = 1'b0;
    tick();

    // Backpressure on word 1
    i_dbg_ready = 1'b0;
    for (int i = 0; i < DW; i++) push_word(i, TD'(32'h100 + i));
    pulse_start();
    wait_valid(10);
    check("bp_addr0", 64'(o_dbg_addr), 64'd0);
    accept_one();
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    64'(o_dbg_valid), 64'd1);
      check("bp_data",     64'(o_dbg_data),  64'h101);
      check("bp_addr",     64'(o_dbg_addr),  64'd1);
      check("bp_mem_addr", 64'(o_mem_addr),  64'h4);
      check("bp_mem_wr",   64'(o_mem_wr_en), 64'd0);
      @(negedge i_clock);
    end
    @(posedge i_clock);
    #1 i_dbg_ready = 1'b1;
    wait_done(30);
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Collision: start together with a pipe load
    for (int i = 0; i < DW; i++) push_word(i, TD'(32'h100 + i));
    i_dbg_dump_start = 1'b1;
    i_pipe_rd_mem    = 1'b1;
    i_pipe_addr      = 32'h20;
    @(negedge i_clock);
    check("col_stall0", 64'(o_pipe_stall), 64'd0);
    check("col_addr0",  64'(o_mem_addr),   64'h20);
    tick();
    i_dbg_dump_start = 1'b0;
    @(negedge i_clock);
    check("col_stall1", 64'(o_pipe_stall), 64'd1);
    check("col_busy1",  64'(o_dbg_busy),   64'd1);
    check("col_valid1", 64'(o_dbg_valid),  64'd0);
    tick();
    i_pipe_rd_mem = 1'b0;
    @(negedge i_clock);
    check("col_busy2",  64'(o_dbg_busy),   64'd1);
    check("col_stall2", 64'(o_pipe_stall), 64'd0);
    wait_valid(10);
    @(posedge i_clock);
    #1;
    i_pipe_wr_mem   = 1'b1;
    i_pipe_addr     = 32'h0;
    i_pipe_data     = 32'hFFFFFFFF;
    i_pipe_byte_enb = 4'hF;
    @(negedge i_clock);
    check("col_dump_stall", 64'(o_pipe_stall), 64'd1);
    check("col_dump_wr_en", 64'(o_mem_wr_en),  64'd0);
    tick();
    i_pipe_wr_mem = 1'b0;
    wait_done(30);
    check("col_q_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Mid-dump reset while word 2 is presented
    i_dbg_ready = 1'b0;
    push_word(0, 32'h100);
    push_word(1, 32'h101);
    pulse_start();
    wait_valid(10);
    accept_one();
    wait_valid(10);
    accept_one();
    wait_valid(10);
    check("mr_addr2", 64'(o_dbg_addr), 64'd2);
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    #1;
    check("mr_valid", 64'(o_dbg_valid), 64'd0);
    check("mr_busy",  64'(o_dbg_busy),  64'd0);
    check("mr_data",  64'(o_dbg_data),  64'd0);
    check("mr_q",     64'(exp_q.size()), 64'd0);
    tick();
    i_reset = 1'b0;
    tick();
    check("mr_idle_busy", 64'(o_dbg_busy), 64'd0);
    i_dbg_ready = 1'b1;
    for (int i = 0; i < DW; i++) push_word(i, TD'(32'h100 + i));
    pulse_start();
    wait_done(30);
    check("mr_q_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Zero words: skipped with DUMP_SKIP_ZERO_EN, presented otherwise
    pipe_write(32'h0, 32'h0);
    pipe_write(32'h4, 32'h5);
    pipe_write(32'h8, 32'h0);
    pipe_write(32'hC, 32'h7);
`ifdef DUMP_SKIP_ZERO_EN
    push_word(1, 32'h5);
    push_word(3, 32'h7);
`else
    push_word(0, 32'h0);
    push_word(1, 32'h5);
    push_word(2, 32'h0);
    push_word(3, 32'h7);
`endif
    pulse_start();
    wait_done(30);
    check("sz_q_empty", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    check("done_total", 64'(done_cnt), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
